writeback_stage: RTL and testbench
==================================

WRITEBACK_STAGE -- requirements
Module: writeback_stage

Interface
REQ-001 Parameter RETIRE_W, default 32: width of the retired-instruction counter.
REQ-002 i_clk  in  1  sole clock; all state updates on its rising edge.
REQ-003 i_rst_n  in  1  asynchronous, active-low reset.
REQ-004 i_valid  in  1  MEM-stage instruction valid this cycle.
REQ-005 i_flush  in  1  kill the instruction presented this cycle.
REQ-006 i_rd  in  5  destination register number.
REQ-007 i_rd_wen  in  1  instruction writes rd.
REQ-008 i_wb_sel  in  2  result source: 00 ALU, 01 load, 10 PC+4, 11 reserved.
REQ-009 i_funct3  in  3  load width/sign code (RV32I encoding).
REQ-010 i_alu_res  in  32  ALU result; bits [1:0] are the load byte offset.
REQ-011 i_ld_data  in  32  raw aligned 32-bit word from data memory.
REQ-012 i_pc4  in  32  PC+4 for JAL/JALR link.
REQ-013 o_Wen  out  1  register-file write enable.
REQ-014 o_Wnum  out  5  register-file write index.
REQ-015 o_Wd  out  32  register-file write data.
REQ-016 o_ld_err  out  1  load misaligned or illegal funct3, one-cycle pulse.
REQ-017 o_retire_cnt  out  RETIRE_W  retired-instruction count.

Function
REQ-018 Capture at each rising edge: WB valid <= i_valid & ~i_flush; i_flush takes precedence over i_valid.
REQ-019 Latency exactly one cycle: instruction presented in cycle N drives o_Wen/o_Wnum/o_Wd during N+1, all registered, no combinational input-to-output path.
REQ-020 Data select before the register: 00 -> i_alu_res; 01 -> formatted load; 10 -> i_pc4.
REQ-021 Load format, off = i_alu_res[1:0]: LB(000) sign-extend byte[off]; LBU(100) zero-extend byte[off]; LH(001) sign-extend half[off[1]]; LHU(101) zero-extend half[off[1]]; LW(010) full word.
REQ-022 Load error when wb_sel=01 and (funct3 in {011,110,111}, or LH/LHU with off[0]=1, or LW with off!=00).
REQ-023 o_Wen = valid & i_rd_wen & (rd!=0) & ~error & (wb_sel!=11); x0 writes and reserved select always suppressed.
REQ-024 o_ld_err high for exactly the one WB cycle of the faulting valid instruction; o_Wd then 0.
REQ-025 o_retire_cnt increments by 1 for each valid WB cycle without load error, regardless of rd_wen; wraps from all-ones to 0.
REQ-026 Back-to-back valid instructions (including same rd) each produce one independent WB cycle; no merging, no stalls.
REQ-027 When WB is not valid: o_Wen=0, o_ld_err=0, o_Wnum=0, o_Wd=0.

Reset
REQ-028 i_rst_n low immediately (asynchronously) forces WB valid=0, o_Wen=0, o_Wnum=0, o_Wd=0, o_ld_err=0, o_retire_cnt=0.
REQ-029 Reset asserted mid-operation discards the in-flight instruction; no write and no count for it after release.
REQ-030 First capture occurs at the first rising edge with i_rst_n high.

Configuration
REQ-031 Macro WB_BYPASS_EN, when defined, adds ports i_Rnum1/i_Rnum2 (in 5), i_Rd1/i_Rd2 (in 32), o_fwd_Rd1/o_fwd_Rd2 (out 32).
REQ-032 With WB_BYPASS_EN: o_fwd_RdK = o_Wd when o_Wen & (o_Wnum==i_RnumK) & (i_RnumK!=0), else i_RdK; purely combinational, closing the same-cycle read-after-write gap of the register file.
REQ-033 Without WB_BYPASS_EN these six ports and the logic are absent; all other behaviour identical.

Verification
REQ-034 Reset release, idle 5 cycles -> o_Wen=0, o_retire_cnt=0 throughout.
REQ-035 i_valid=1, wb_sel=01, funct3=000, i_alu_res=0x1003, i_ld_data=0x80FF7F00, rd=5 -> next cycle o_Wen=1, o_Wnum=5, o_Wd=0xFFFFFF80; LBU same -> 0x00000080.
REQ-036 LW with i_alu_res=0x2002 -> o_ld_err=1 one cycle, o_Wen=0, count unchanged; LH off=2 data 0x8001xxxx -> o_Wd=0xFFFF8001.
REQ-037 i_valid=1 & i_flush=1 -> no write, no count; rd=0 wb_sel=00 -> o_Wen=0, count +1; RETIRE_W=4 with 16 retires -> counter returns to 0.
REQ-038 i_rst_n pulsed low mid-cycle during WB of rd=7 -> o_Wen falls immediately, count 0; with WB_BYPASS_EN, o_Wen=1 o_Wnum=3 o_Wd=0xDEADBEEF, i_Rnum1=3 i_Rd1=0 -> o_fwd_Rd1=0xDEADBEEF; i_Rnum2=0 -> o_fwd_Rd2=i_Rd2.

Source files
------------

// File: rtl/writeback_stage.sv
// Writeback stage: selects the result, formats loads, flags load faults and counts retired instructions.
// Optional macro WB_BYPASS_EN adds a combinational register-file read bypass.
module writeback_stage #(
  parameter int RETIRE_W = 32
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_valid,
  input  logic                i_flush,
  input  logic [4:0]          i_rd,
  input  logic                i_rd_wen,
  input  logic [1:0]          i_wb_sel,
  input  logic [2:0]          i_funct3,
  input  logic [31:0]         i_alu_res,
  input  logic [31:0]         i_ld_data,
  input  logic [31:0]         i_pc4,
`ifdef WB_BYPASS_EN
  input  logic [4:0]          i_Rnum1,
  input  logic [4:0]          i_Rnum2,
  input  logic [31:0]         i_Rd1,
  input  logic [31:0]         i_Rd2,
  output logic [31:0]         o_fwd_Rd1,
  output logic [31:0]         o_fwd_Rd2,
`endif
  output logic                o_Wen,
  output logic [4:0]          o_Wnum,
  output logic [31:0]         o_Wd,
  output logic                o_ld_err,
  output logic [RETIRE_W-1:0] o_retire_cnt
);

  // Returns {error, data}: extracts and extends the addressed byte/half/word.
  function automatic logic [32:0] ld_format(input logic [2:0]  f3,
                                            input logic [1:0]  off,
                                            input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    logic [32:0] r;
    b = word[{off, 3'b000} +: 8];
    h = off[1] ? word[31:16] : word[15:0];
    case (f3)
      3'b000:  r = {1'b0, {24{b[7]}}, b};
      3'b100:  r = {1'b0, 24'h000000, b};
      3'b001:  r = off[0] ? {1'b1, 32'h0000_0000} : {1'b0, {16{h[15]}}, h};
      3'b101:  r = off[0] ? {1'b1, 32'h0000_0000} : {1'b0, 16'h0000, h};
      3'b010:  r = (off != 2'b00) ? {1'b1, 32'h0000_0000} : {1'b0, word};
      default: r = {1'b1, 32'h0000_0000};
    endcase
    return r;
  endfunction

  logic                valid_s;
  logic                ld_err_s;
  logic [31:0]         wd_s;
  logic                wen_s;
  logic [32:0]         ld_s;
  logic                wen_r;
  logic [4:0]          wnum_r;
  logic [31:0]         wd_r;
  logic                ld_err_r;
  logic [RETIRE_W-1:0] cnt_r;

  // Result selection and write-enable qualification ahead of the WB register.
  always_comb begin
    valid_s  = i_valid & ~i_flush;
    ld_s     = ld_format(i_funct3, i_alu_res[1:0], i_ld_data);
    ld_err_s = 1'b0;
    wd_s     = 32'h0000_0000;
    case (i_wb_sel)
      2'b00:   wd_s = i_alu_res;
      2'b01: begin
        ld_err_s = ld_s[32];
        wd_s     = ld_s[31:0];
      end
      2'b10:   wd_s = i_pc4;
      default: wd_s = 32'h0000_0000;
    endcase
    wen_s = valid_s & i_rd_wen & (i_rd != 5'd0) & ~ld_err_s & (i_wb_sel != 2'b11);
  end

  // WB register: invalid slots and faulting loads drive zeros.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wen_r    <= 1'b0;
      wnum_r   <= 5'd0;
      wd_r     <= 32'h0000_0000;
      ld_err_r <= 1'b0;
      cnt_r    <= '0;
    end else begin
      wen_r    <= wen_s;
      wnum_r   <= valid_s ? i_rd : 5'd0;
      wd_r     <= (valid_s & ~ld_err_s) ? wd_s : 32'h0000_0000;
      ld_err_r <= valid_s & ld_err_s;
      if (valid_s && !ld_err_s) begin
        cnt_r <= cnt_r + {{(RETIRE_W-1){1'b0}}, 1'b1};
      end else begin
        cnt_r <= cnt_r;
      end
    end
  end

  assign o_Wen        = wen_r;
  assign o_Wnum       = wnum_r;
  assign o_Wd         = wd_r;
  assign o_ld_err     = ld_err_r;
  assign o_retire_cnt = cnt_r;

`ifdef WB_BYPASS_EN
  // Same-cycle read-after-write forwarding around the register file.
  always_comb begin
    if (wen_r && (wnum_r == i_Rnum1) && (i_Rnum1 != 5'd0)) begin
      o_fwd_Rd1 = wd_r;
    end else begin
      o_fwd_Rd1 = i_Rd1;
    end
    if (wen_r && (wnum_r == i_Rnum2) && (i_Rnum2 != 5'd0)) begin
      o_fwd_Rd2 = wd_r;
    end else begin
      o_fwd_Rd2 = i_Rd2;
    end
  end
`endif

endmodule

// File: tb/tb_writeback_stage.sv
// Randomized + directed bench for writeback_stage against a behavioural reference model.
// Define WB_BYPASS_EN to also exercise the forwarding ports.
module tb_writeback_stage;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_valid, i_flush, i_rd_wen;
  logic [4:0]  i_rd;
  logic [1:0]  i_wb_sel;
  logic [2:0]  i_funct3;
  logic [31:0] i_alu_res, i_ld_data, i_pc4;
  logic [4:0]  i_Rnum1, i_Rnum2;
  logic [31:0] i_Rd1, i_Rd2;
  logic [31:0] o_fwd_Rd1, o_fwd_Rd2, f4_Rd1, f4_Rd2;
  logic        o_Wen, o_ld_err, w4_wen, w4_err;
  logic [4:0]  o_Wnum, w4_wnum;
  logic [31:0] o_Wd, w4_wd;
  logic [31:0] o_retire_cnt;
  logic [3:0]  cnt4;

  int checks = 0;
  int errors = 0;

  logic        e_wen, e_err;
  logic [4:0]  e_wnum;
  logic [31:0] e_wd, e_cnt;
  logic [3:0]  e_cnt4;

  always #5 i_clk = ~i_clk;

  writeback_stage dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .i_flush(i_flush),
    .i_rd(i_rd), .i_rd_wen(i_rd_wen), .i_wb_sel(i_wb_sel), .i_funct3(i_funct3),
    .i_alu_res(i_alu_res), .i_ld_data(i_ld_data), .i_pc4(i_pc4),
`ifdef WB_BYPASS_EN
    .i_Rnum1(i_Rnum1), .i_Rnum2(i_Rnum2), .i_Rd1(i_Rd1), .i_Rd2(i_Rd2),
    .o_fwd_Rd1(o_fwd_Rd1), .o_fwd_Rd2(o_fwd_Rd2),
`endif
    .o_Wen(o_Wen), .o_Wnum(o_Wnum), .o_Wd(o_Wd), .o_ld_err(o_ld_err),
    .o_retire_cnt(o_retire_cnt)
  );

  writeback_stage #(.RETIRE_W(4)) dut4 (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .i_flush(i_flush),
    .i_rd(i_rd), .i_rd_wen(i_rd_wen), .i_wb_sel(i_wb_sel), .i_funct3(i_funct3),
    .i_alu_res(i_alu_res), .i_ld_data(i_ld_data), .i_pc4(i_pc4),
`ifdef WB_BYPASS_EN
    .i_Rnum1(i_Rnum1), .i_Rnum2(i_Rnum2), .i_Rd1(i_Rd1), .i_Rd2(i_Rd2),
    .o_fwd_Rd1(f4_Rd1), .o_fwd_Rd2(f4_Rd2),
`endif
    .o_Wen(w4_wen), .o_Wnum(w4_wnum), .o_Wd(w4_wd), .o_ld_err(w4_err),
    .o_retire_cnt(cnt4)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%08h expected=%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input logic fl, input logic [4:0] rd, input logic wen,
                       input logic [1:0] sel, input logic [2:0] f3, input logic [31:0] alu,
                       input logic [31:0] ld, input logic [31:0] pc4);
    i_valid = v; i_flush = fl; i_rd = rd; i_rd_wen = wen; i_wb_sel = sel;
    i_funct3 = f3; i_alu_res = alu; i_ld_data = ld; i_pc4 = pc4;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 5'd0, 1'b0, 2'b00, 3'b000, 32'd0, 32'd0, 32'd0);
  endtask

  // Reference: what the WB slot should show after capturing the current inputs.
  task automatic model_capture();
    logic [31:0] off, b, h, res;
    logic        err, v;
    off = i_alu_res % 32'd4;
    v   = i_valid && !i_flush;
    err = 1'b0;
    res = 32'd0;
    b   = (i_ld_data >> (off * 32'd8)) % 32'd256;
    h   = (i_ld_data >> ((off / 32'd2) * 32'd16)) % 32'd65536;
    if (i_wb_sel == 2'd0) res = i_alu_res;
    else if (i_wb_sel == 2'd2) res = i_pc4;
    else if (i_wb_sel == 2'd1) begin
      if (i_funct3 == 3'd0) res = (b >= 32'd128) ? b - 32'd256 : b;
      else if (i_funct3 == 3'd4) res = b;
      else if (i_funct3 == 3'd1 || i_funct3 == 3'd5) begin
        if (off % 32'd2 != 32'd0) err = 1'b1;
        else if (i_funct3 == 3'd1 && h >= 32'd32768) res = h - 32'd65536;
        else res = h;
      end else if (i_funct3 == 3'd2) begin
        if (off != 32'd0) err = 1'b1;
        else res = i_ld_data;
      end else err = 1'b1;
    end
    if (err) res = 32'd0;
    if (v) begin
      e_wen  = i_rd_wen && (i_rd != 5'd0) && !err && (i_wb_sel != 2'd3);
      e_wnum = i_rd;
      e_wd   = res;
      e_err  = err;
      if (!err) begin
        e_cnt  = e_cnt + 32'd1;
        e_cnt4 = e_cnt4 + 4'd1;
      end
    end else begin
      e_wen = 1'b0; e_wnum = 5'd0; e_wd = 32'd0; e_err = 1'b0;
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    model_capture();
    #1;
    check("wen", {31'd0, o_Wen}, {31'd0, e_wen});
    check("wnum", {27'd0, o_Wnum}, {27'd0, e_wnum});
    check("wd", o_Wd, e_wd);
    check("ld_err", {31'd0, o_ld_err}, {31'd0, e_err});
    check("cnt", o_retire_cnt, e_cnt);
    check("cnt4", {28'd0, cnt4}, {28'd0, e_cnt4});
  endtask

  task automatic model_reset();
    e_wen = 1'b0; e_wnum = 5'd0; e_wd = 32'd0; e_err = 1'b0; e_cnt = 32'd0; e_cnt4 = 4'd0;
  endtask

  logic [31:0] cnt_before;

  initial begin
    i_Rnum1 = 5'd0; i_Rnum2 = 5'd0; i_Rd1 = 32'd0; i_Rd2 = 32'd0;
    idle();
    model_reset();
    i_rst_n = 1'b0;
    #3;
    check("rst_wen", {31'd0, o_Wen}, 32'd0);
    check("rst_cnt", o_retire_cnt, 32'd0);
    #9 i_rst_n = 1'b1;

    for (int i = 0; i < 5; i++) begin
      step();
      check("idle_wen", {31'd0, o_Wen}, 32'd0);
      check("idle_cnt", o_retire_cnt, 32'd0);
    end

    drive(1'b1, 1'b0, 5'd5, 1'b1, 2'b01, 3'b000, 32'h0000_1003, 32'h80FF_7F00, 32'd0);
    step();
    check("lb_wen", {31'd0, o_Wen}, 32'd1);
    check("lb_wnum", {27'd0, o_Wnum}, 32'd5);
    check("lb_wd", o_Wd, 32'hFFFF_FF80);
    i_funct3 = 3'b100;
    step();
    check("lbu_wd", o_Wd, 32'h0000_0080);

    cnt_before = e_cnt;
    drive(1'b1, 1'b0, 5'd6, 1'b1, 2'b01, 3'b010, 32'h0000_2002, 32'h1234_5678, 32'd0);
    step();
    check("lw_err", {31'd0, o_ld_err}, 32'd1);
    check("lw_err_wen", {31'd0, o_Wen}, 32'd0);
    check("lw_err_cnt", o_retire_cnt, cnt_before);
    drive(1'b1, 1'b0, 5'd6, 1'b1, 2'b01, 3'b001, 32'h0000_2002, 32'h8001_5A5A, 32'd0);
    step();
    check("lw_err_pulse", {31'd0, o_ld_err}, 32'd0);
    check("lh_wd", o_Wd, 32'hFFFF_8001);

    cnt_before = e_cnt;
    drive(1'b1, 1'b1, 5'd9, 1'b1, 2'b00, 3'b000, 32'h1111_2222, 32'd0, 32'd0);
    step();
    check("flush_wen", {31'd0, o_Wen}, 32'd0);
    check("flush_cnt", o_retire_cnt, cnt_before);
    drive(1'b1, 1'b0, 5'd0, 1'b1, 2'b00, 3'b000, 32'h3333_4444, 32'd0, 32'd0);
    step();
    check("x0_wen", {31'd0, o_Wen}, 32'd0);
    check("x0_cnt", o_retire_cnt, cnt_before + 32'd1);

    // Asynchronous reset while rd=7 sits in WB
    drive(1'b1, 1'b0, 5'd7, 1'b1, 2'b10, 3'b000, 32'd0, 32'd0, 32'h0000_0104);
    step();
    check("pre_rst_wen", {31'd0, o_Wen}, 32'd1);
    #2 i_rst_n = 1'b0;
    #1;
    model_reset();
    check("async_rst_wen", {31'd0, o_Wen}, 32'd0);
    check("async_rst_cnt", o_retire_cnt, 32'd0);
    idle();
    #1 i_rst_n = 1'b1;
    step();
    check("post_rst_wen", {31'd0, o_Wen}, 32'd0);

    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 1'b0, 5'd1, 1'b1, 2'b00, 3'b000, 32'(i), 32'd0, 32'd0);
      step();
    end
    check("wrap4", {28'd0, cnt4}, 32'd0);
    check("cnt16", o_retire_cnt, 32'd16);

`ifdef WB_BYPASS_EN
    drive(1'b1, 1'b0, 5'd3, 1'b1, 2'b00, 3'b000, 32'hDEAD_BEEF, 32'd0, 32'd0);
    step();
    i_Rnum1 = 5'd3; i_Rd1 = 32'd0; i_Rnum2 = 5'd0; i_Rd2 = 32'h0BAD_F00D;
    #1;
    check("fwd_rd1", o_fwd_Rd1, 32'hDEAD_BEEF);
    check("fwd_rd2_x0", o_fwd_Rd2, 32'h0BAD_F00D);
    i_Rnum2 = 5'd4;
    #1;
    check("fwd_rd2_miss", o_fwd_Rd2, 32'h0BAD_F00D);
`endif

    for (int i = 0; i < 400; i++) begin
      drive(($urandom % 4) != 0, ($urandom % 8) == 0, 5'($urandom % 32), 1'($urandom % 2),
            2'($urandom % 4), 3'($urandom % 8), $urandom, $urandom, $urandom);
      if ($urandom % 4 == 0) i_rd = 5'd0;
      step();
`ifdef WB_BYPASS_EN
      i_Rnum1 = ($urandom % 2 == 0) ? e_wnum : 5'($urandom % 32);
      i_Rd1 = $urandom;
      #1;
      check("rnd_fwd", o_fwd_Rd1, (e_wen && e_wnum == i_Rnum1 && i_Rnum1 != 5'd0) ? e_wd : i_Rd1);
`endif
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
